// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - fetch unit bus bundle: instruction memory, redirect, decode-side output
//
// Signals:
//   pc_addr / imem_*            fetch address out, same-cycle memory response in
//   redirect_en / redirect_pc   branch/jump/trap redirect request
//   out_*                       head FIFO entry toward decode (valid/ready handshake)
//   fault_wait                  fetch halted after a fault, waiting for redirect
// Modports: master = fetch unit side, slave = memory/decode/control side.
interface ifetch_if;
    logic [63:0] pc_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;
    logic        fault_wait;

    modport master (
        output pc_addr,
        input  imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
        input  redirect_en, redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val,
        output fault_wait
    );

    modport slave (
        input  pc_addr,
        output imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
        output redirect_en, redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc, out_instr, out_exc_en, out_exc_code, out_exc_val,
        input  fault_wait
    );
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch unit with 2-entry output FIFO and fault halt
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   fif   ifetch_if.master (pc_addr, imem_*, redirect_*, out_*, fault_wait)
// Parameters: RESET_PC (PC after reset), NOP_INSTR (instruction shown when no valid entry).
// Build option: IFETCH_MISALIGN_CHECK_EN - misaligned redirect targets raise a fetch
//   exception entry (code 0) instead of being silently aligned down.
module ifetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input logic       clk,
    input logic       rst,
    ifetch_if.master  fif
);
    typedef enum logic {FETCH, FAULT_WAIT} state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } entry_t;

    entry_t      fifo_q [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [63:0] pc;
    state_t      state;

    logic        out_valid;
    logic        pop;
    logic        push;
    entry_t      new_entry;
    entry_t      head;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && fif.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = (state == FETCH) && !fif.redirect_en && ((count < 2'd2) || pop);

    always_comb begin
        new_entry          = '0;
        new_entry.pc       = pc;
        new_entry.instr    = fif.imem_exc_en ? NOP_INSTR : fif.imem_instr;
        new_entry.exc_en   = fif.imem_exc_en;
        new_entry.exc_code = fif.imem_exc_code;
        new_entry.exc_val  = fif.imem_exc_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            pc     <= RESET_PC;
            state  <= FETCH;
        end else if (fif.redirect_en) begin
            // Redirect wins over everything: stale entries are dropped outright.
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            state  <= FETCH;
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (fif.redirect_pc[1:0] != 2'b00) begin
                fifo_q[0] <= '{pc: fif.redirect_pc, instr: NOP_INSTR, exc_en: 1'b1,
                               exc_code: 4'd0, exc_val: fif.redirect_pc};
                wr_ptr    <= 1'b1;
                count     <= 2'd1;
                pc        <= fif.redirect_pc;
                state     <= FAULT_WAIT;
            end else begin
                pc <= fif.redirect_pc;
            end
`else
            pc <= fif.redirect_pc & ~64'h3;
`endif
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= new_entry;
                wr_ptr         <= ~wr_ptr;
                if (fif.imem_exc_en) begin
                    state <= FAULT_WAIT;
                end else begin
                    pc <= pc + 64'd4;
                end
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head             = fifo_q[rd_ptr];
    assign fif.pc_addr      = pc;
    assign fif.out_valid    = out_valid;
    assign fif.out_pc       = out_valid ? head.pc       : 64'd0;
    assign fif.out_instr    = out_valid ? head.instr    : NOP_INSTR;
    assign fif.out_exc_en   = out_valid ? head.exc_en   : 1'b0;
    assign fif.out_exc_code = out_valid ? head.exc_code : 4'd0;
    assign fif.out_exc_val  = out_valid ? head.exc_val  : 64'd0;
    assign fif.fault_wait   = (state == FAULT_WAIT);
endmodule
